// File: rtl/sub32_seq.sv
// sub32_seq -- time-folded ripple subtractor.
//
// Computes D = A - B - BI one SLICE-bit chunk per clock, starting with the
// least significant chunk. The subtraction is formed as A + ~B + ~BI through
// one SLICE+1 bit adder, and the carry is held in a register between cycles.
// This trades latency (WIDTH/SLICE cycles) for a very small adder.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset (overrides everything)
//   start  operation request, accepted in IDLE or DONE only
//   a      minuend,    sampled on the accepting edge only
//   b      subtrahend, sampled on the accepting edge only
//   bi     borrow in,  sampled on the accepting edge only
//   busy   high while the slices are being processed
//   done   one-cycle pulse, d/bo/ovf valid from this cycle on
//   d      registered difference (modulo 2^WIDTH)
//   bo     registered borrow out (1 = unsigned a < b + bi)
//   ovf    registered signed two's-complement overflow
module sub32_seq #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bi,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bo,
  output logic             ovf
);

  localparam int N     = WIDTH / SLICE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] wa_q;      // minuend
  logic [WIDTH-1:0] wb_q;      // inverted subtrahend
  logic [WIDTH-1:0] wr_q;      // partial result, filled slice by slice
  logic             c_q;       // carry between slices (inverted borrow)
  logic             bsign_q;   // original sign of b, needed for ovf
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] d_q;
  logic             bo_q;
  logic             ovf_q;

  logic [SLICE:0]   slice_sum;
  logic [WIDTH-1:0] wr_d;
  logic             ovf_d;

  // One slice of the folded ripple chain. The adder is exactly SLICE+1 bits
  // wide; its top bit is the carry into the next slice.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned, which would infer a latch.
    slice_sum = '0;
    wr_d      = wr_q;
    ovf_d     = 1'b0;
    slice_sum = {1'b0, wa_q[int'(cnt_q)*SLICE +: SLICE]}
              + {1'b0, wb_q[int'(cnt_q)*SLICE +: SLICE]}
              + {{SLICE{1'b0}}, c_q};
    wr_d[int'(cnt_q)*SLICE +: SLICE] = slice_sum[SLICE-1:0];
    // Overflow only possible when operand signs differ and the result sign
    // departs from the minuend's sign.
    ovf_d = (wa_q[WIDTH-1] != bsign_q) && (wr_d[WIDTH-1] != wa_q[WIDTH-1]);
  end

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wa_q    <= '0;
      wb_q    <= '0;
      wr_q    <= '0;
      c_q     <= 1'b0;
      bsign_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      d_q     <= '0;
      bo_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            wa_q    <= a;
            wb_q    <= ~b;
            c_q     <= ~bi;
            bsign_q <= b[WIDTH-1];
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          wr_q  <= wr_d;
          c_q   <= slice_sum[SLICE];
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            // Completing edge: publish the merged result and flags.
            cnt_q   <= '0;
            d_q     <= wr_d;
            bo_q    <= ~slice_sum[SLICE];
            ovf_q   <= ovf_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign d    = d_q;
  assign bo   = bo_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_sub32_seq.sv
// tb_sub32_seq -- self-checking bench for sub32_seq.
//
// Expected results come from a plain-arithmetic model of A - B - BI using
// 64-bit integers; handshake timing is checked against cycle counts.
module tb_sub32_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        bi;
  logic        busy;
  logic        done;
  logic [31:0] d;
  logic        bo;
  logic        ovf;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] exp_d   = '0;
  logic        exp_bo  = 1'b0;
  logic        exp_ovf = 1'b0;

  sub32_seq #(.WIDTH(32), .SLICE(4)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .bi    (bi),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bo    (bo),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  // Reference: exact integer arithmetic, then reduce to the 32-bit view.
  task automatic model(input logic [31:0] ma, input logic [31:0] mb, input logic mbi,
                       output logic [31:0] md, output logic mbo, output logic movf);
    longint ud;
    longint sd;
    ud   = longint'({32'h0, ma}) - longint'({32'h0, mb}) - longint'(mbi);
    sd   = longint'($signed(ma)) - longint'($signed(mb)) - longint'(mbi);
    md   = ud[31:0];
    mbo  = (ud < 0);
    movf = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
  endtask

  // Present an operation and let the next rising edge accept it. Returns
  // #1 after the accepting edge with start low and junk on the operands.
  task automatic start_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic tbi);
    @(negedge clk);
    a = ta; b = tb_v; bi = tbi; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom; bi = 1'($urandom);
    check("busy_after_accept", 32'(busy), 32'd1);
  endtask

  // Wait for done (bounded), checking busy and held outputs on the way,
  // then check the result. poke >= 0 raises start for one cycle mid-run.
  task automatic wait_result(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                             input logic tbi, input int poke, output int done_cyc);
    int n = 0;
    logic [31:0] md;
    logic        mbo;
    logic        movf;
    model(ta, tb_v, tbi, md, mbo, movf);
    while (!done && n < 20) begin
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_hold_d"}, d, exp_d);
      if (n == poke) begin
        start = 1'b1; a = $urandom; b = $urandom; bi = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    check({tag, "_latency"}, 32'(n), 32'd8);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
    check({tag, "_d"}, d, md);
    check({tag, "_bo"}, 32'(bo), 32'(mbo));
    check({tag, "_ovf"}, 32'(ovf), 32'(movf));
    exp_d = md; exp_bo = mbo; exp_ovf = movf;
    done_cyc = cyc;
  endtask

  task automatic full_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                         input logic tbi);
    int dc;
    start_op(ta, tb_v, tbi);
    wait_result(tag, ta, tb_v, tbi, -1, dc);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_idle_d"}, d, exp_d);
  endtask

  initial begin
    int c1;
    int c2;
    reset = 1'b1; start = 1'b0; a = '0; b = '0; bi = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_d", d, 32'd0);
    check("rst_bo", 32'(bo), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    reset = 1'b0;

    // Directed patterns.
    full_op("basic",   32'h0000_0005, 32'h0000_0003, 1'b0);
    full_op("under",   32'h0000_0000, 32'h0000_0001, 1'b0);
    full_op("ovf_neg", 32'h8000_0000, 32'h0000_0001, 1'b0);
    full_op("ovf_pos", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    full_op("bi_eq",   32'h0000_0010, 32'h0000_0010, 1'b1);
    full_op("bi_mix",  32'h1234_5678, 32'h0234_5670, 1'b1);

    // start during RUN is ignored; then back-to-back with start held in DONE.
    start_op(32'h0000_1000, 32'h0000_0001, 1'b0);
    wait_result("ignore", 32'h0000_1000, 32'h0000_0001, 1'b0, 3, c1);
    a = 32'd9; b = 32'd4; bi = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_done_low", 32'(done), 32'd0);
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_hold_d", d, exp_d);
    wait_result("b2b", 32'd9, 32'd4, 1'b0, -1, c2);
    check("b2b_spacing", 32'(c2 - c1), 32'd9);
    @(posedge clk); #1;
    check("b2b_done_pulse", 32'(done), 32'd0);

    // Reset in the middle of RUN aborts with no done pulse.
    start_op(32'hDEAD_BEEF, 32'h0123_4567, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_d", d, 32'd0);
    check("mid_rst_bo", 32'(bo), 32'd0);
    check("mid_rst_ovf", 32'(ovf), 32'd0);
    exp_d = '0; exp_bo = 1'b0; exp_ovf = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      check("mid_rst_no_done", 32'(done), 32'd0);
    end
    full_op("after_rst", 32'h0000_0064, 32'h0000_0032, 1'b0);

    // Randomized operands, with a bias toward sign-boundary values.
    for (int i = 0; i < 24; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = $urandom;
      if (i % 4 == 1) ra = {ra[31], 31'h7FFF_FFFF ^ {31{ra[0]}}};
      if (i % 4 == 2) rb = ra;
      full_op("rand", ra, rb, 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
